// File: rtl/kf76489_write_queue_pkg.sv
// Shared types and default parameters for the sound-chip write queue.
package kf76489_write_queue_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StWaitRdy,
    StRelease
  } state_e;

  localparam int unsigned DefaultDepth      = 8;
  localparam int unsigned DefaultAckTimeout = 64;
  localparam int unsigned DefaultGap        = 1;

endpackage

// File: rtl/kf76489_write_queue_fifo.sv
// Byte FIFO with wrap-bit pointers; push while full and pop while empty are ignored.
module kf76489_write_queue_fifo
  import kf76489_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic [AddrW:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]     mem_q [DEPTH];
  logic           do_push;
  logic           do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  // Same slot but opposite lap means the writer is a full turn ahead.
  assign full  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;

  assign head_data = mem_q[rd_ptr_q[AddrW-1:0]];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
  end

endmodule

// File: rtl/kf76489_write_queue.sv
// Queues host bytes and replays them to the sound chip with a CE_N/WE_N strobe,
// waiting for the chip's READY handshake (with timeout) on every write.
module kf76489_write_queue
  import kf76489_write_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = DefaultDepth,
  parameter int unsigned ACK_TIMEOUT = DefaultAckTimeout,
  parameter int unsigned GAP         = DefaultGap
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [7:0]             wr_data,
  output logic                   wr_ready,
  input  logic                   clear_err,
  output logic                   CE_N,
  output logic                   WE_N,
  output logic [7:0]             D_IN,
  input  logic                   READY,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   overflow,
  output logic                   timeout_err
);

  localparam int unsigned TimerW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW   = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(ACK_TIMEOUT - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(GAP - 1);

  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        d_in_q, d_in_d;
  logic              overflow_q, overflow_d;
  logic              timeout_q, timeout_d;

  logic              fifo_pop;
  logic [7:0]        fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              timeout_set;

  kf76489_write_queue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (wr_valid),
    .push_data (wr_data),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wr_ready = !fifo_full;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    gap_d       = gap_q;
    strobe_d    = strobe_q;
    d_in_d      = d_in_q;
    fifo_pop    = 1'b0;
    timeout_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          d_in_d   = fifo_head;
          strobe_d = 1'b0;
          timer_d  = '0;
          state_d  = StAssert;
        end
      end
      StAssert: begin
        // A chip acknowledge takes priority over a timeout in the same cycle.
        if (!READY) begin
          state_d = StWaitRdy;
        end else if (timer_q == TimerLast) begin
          timeout_set = 1'b1;
          strobe_d    = 1'b1;
          gap_d       = '0;
          state_d     = StRelease;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitRdy: begin
        if (READY) begin
          strobe_d = 1'b1;
          gap_d    = '0;
          state_d  = StRelease;
        end
      end
      StRelease: begin
        if (gap_q == GapLast) state_d = StIdle;
        else                  gap_d   = gap_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Set events win over a simultaneous clear.
  always_comb begin
    overflow_d = overflow_q;
    timeout_d  = timeout_q;
    if (clear_err) begin
      overflow_d = 1'b0;
      timeout_d  = 1'b0;
    end
    if (wr_valid && fifo_full) overflow_d = 1'b1;
    if (timeout_set)           timeout_d  = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      gap_q      <= '0;
      strobe_q   <= 1'b1;
      d_in_q     <= 8'hFF;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      gap_q      <= gap_d;
      strobe_q   <= strobe_d;
      d_in_q     <= d_in_d;
      overflow_q <= overflow_d;
      timeout_q  <= timeout_d;
    end
  end

  assign CE_N        = strobe_q;
  assign WE_N        = strobe_q;
  assign D_IN        = d_in_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;
  assign overflow    = overflow_q;
  assign timeout_err = timeout_q;

endmodule
